char_decipher: RTL and testbench
================================

Name: char_decipher

Overview:
- Streaming byte decipher: consumes the public key from public_key_gen and a stream of ciphertext characters, and emits plaintext characters.
- Arithmetic is modulo 227: P = (C - Pk) mod 227.
- Sits downstream of public_key_gen in decrypt mode (mode 2'b01).
- Decoupled by valid/ready handshakes on both sides, with an output FIFO.

Parameters:
- P_MOD, 227, cipher modulus; valid characters and keys lie in 0..P_MOD-1.
- FIFO_DEPTH, 4, plaintext output FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  operating mode; 2'b01 = decrypt, all other values = stop/drain.
- pk_in  in  8  public key from public_key_gen.
- pk_ready  in  1  public key valid, level from public_key_gen.
- ct_valid  in  1  ciphertext byte valid.
- ct_data  in  8  ciphertext byte.
- ct_ready  out  1  ciphertext byte accepted this cycle when ct_valid is also 1.
- pt_valid  out  1  plaintext FIFO head valid.
- pt_data  out  8  plaintext FIFO head.
- pt_ready  in  1  sink accepts head.
- key_loaded  out  1  key latched, block in RUN.
- err_invalid_key  out  1  sticky; set when an out-of-range key was offered.
- err_invalid_char  out  1  one-cycle pulse per rejected ciphertext byte.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to WAIT_KEY; key register = 0; FIFO emptied (pointers and count = 0).
  - All outputs 0, including pt_data = 8'h00.
  - Reset mid-stream discards all FIFO contents.
- FSM states: WAIT_KEY, RUN, DRAIN.
- WAIT_KEY:
  - ct_ready = 0.
  - When mode==2'b01 and pk_ready==1:
    - pk_in in 1..P_MOD-1: latch the key, go to RUN, key_loaded=1 from the next cycle, clear err_invalid_key.
    - pk_in outside that range: set err_invalid_key (sticky), stay in WAIT_KEY.
- RUN:
  - ct_ready = (FIFO not full). This is registered-state based; there is no combinational path from pt_ready to ct_ready.
  - When full, a simultaneous pop does not enable a push in the same cycle.
  - Accept on ct_valid & ct_ready:
    - ct_data <= P_MOD-1: push P.
      - ct_data >= key: P = ct_data - key.
      - Otherwise: P = ct_data + P_MOD - key.
      - Computed 9-bit; the result is always 0..P_MOD-1; the low 8 bits are stored.
    - ct_data >= P_MOD: byte consumed and dropped, nothing pushed; err_invalid_char = 1 on the next cycle for exactly one cycle.
  - pk_ready changes in RUN are ignored; the key stays latched.
  - mode != 2'b01: go to DRAIN the next cycle. An accept in the same cycle as the mode change is still processed.
- DRAIN:
  - ct_ready = 0; key_loaded = 0; the FIFO continues to drain.
  - When the FIFO is empty: go to WAIT_KEY and clear the key to 0.
  - mode returning to 2'b01 during DRAIN has no effect until WAIT_KEY is reached.
- FIFO:
  - pt_valid = (count != 0); pt_data = head entry. When empty, pt_data = 8'h00.
  - Pop on pt_valid & pt_ready.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - pt_valid/pt_data stable while pt_valid=1 and pt_ready=0.
- Latency: accept at edge N → pt_valid=1 after edge N (visible cycle N+1) when the FIFO was empty.
- Throughput: 1 byte/cycle with pt_ready held at 1.

Optional Feature:
- Macro: CHAR_DECIPHER_COUNT_EN.
- Defined:
  - Adds output port chars_done [15:0].
  - Increments on every valid ciphertext accept (rejected bytes are not counted).
  - Saturates at 16'hFFFF.
  - Cleared by reset and on entry to WAIT_KEY.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Key load: Sk=10 gives Pk=8. mode=01, pk_in=8, pk_ready=1 → key_loaded=1 next cycle, ct_ready=1.
- Decrypt values with key 8, pt_ready=1:
  - ct 20 → pt 12.
  - ct 8 → pt 0.
  - ct 3 → pt 222 (wrap).
  - ct 226 → pt 218.
  - Each appears one cycle after accept, in order.
- Invalid inputs:
  - pk_in=0 or 227 with pk_ready → err_invalid_key=1, stays in WAIT_KEY.
  - In RUN, ct_data=230 → no push, err_invalid_char pulses for 1 cycle, next ct 20 → 12.
- Backpressure: pt_ready=0, stream 5 valid bytes.
  - ct_ready drops after 4 accepts.
  - Head stays 12 while stalled.
  - Releasing pt_ready drains in order; ct_ready returns the cycle after the first pop.
- Drain and reset:
  - Fill 3 entries, set mode=00 → ct_ready=0, 3 outputs delivered, then key_loaded=0 and WAIT_KEY.
  - Repeat with rst_n asserted mid-drain → pt_valid=0 and key cleared immediately.
- CHAR_DECIPHER_COUNT_EN: 3 valid bytes plus 1 invalid → chars_done=3; re-key via DRAIN → chars_done=0.

Source files
------------

// File: rtl/char_decipher_if.sv
// Handshake bundle for char_decipher: key intake, ciphertext in, plaintext out, status.
// The slave modport is the decipher block; master is whatever drives it.
// Optional CHAR_DECIPHER_COUNT_EN adds the chars_done counter signal.
interface char_decipher_if;
  logic [1:0]  mode;
  logic [7:0]  pk_in;
  logic        pk_ready;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        key_loaded;
  logic        err_invalid_key;
  logic        err_invalid_char;
`ifdef CHAR_DECIPHER_COUNT_EN
  logic [15:0] chars_done;
`endif

  modport master (
    output mode,
    output pk_in,
    output pk_ready,
    output ct_valid,
    output ct_data,
    output pt_ready,
    input  ct_ready,
    input  pt_valid,
    input  pt_data,
    input  key_loaded,
    input  err_invalid_key,
    input  err_invalid_char
`ifdef CHAR_DECIPHER_COUNT_EN
    , input chars_done
`endif
  );

  modport slave (
    input  mode,
    input  pk_in,
    input  pk_ready,
    input  ct_valid,
    input  ct_data,
    input  pt_ready,
    output ct_ready,
    output pt_valid,
    output pt_data,
    output key_loaded,
    output err_invalid_key,
    output err_invalid_char
`ifdef CHAR_DECIPHER_COUNT_EN
    , output chars_done
`endif
  );
endinterface

// File: rtl/char_decipher.sv
// Streaming modular decipher: P = (C - key) mod P_MOD, with a plaintext output FIFO.
// Key is taken from public_key_gen in decrypt mode; leaving decrypt mode drains the FIFO
// and then waits for a fresh key.
// Optional CHAR_DECIPHER_COUNT_EN adds a saturating count of accepted in-range bytes.
module char_decipher #(
  parameter int unsigned P_MOD      = 227,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  char_decipher_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0]  PMod = 9'(P_MOD);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StWaitKey, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic            err_key_q, err_key_d;
  logic            err_char_q, err_char_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic            mode_dec;
  logic            fifo_full, fifo_empty;
  logic            ct_rdy;
  logic            accept, ct_bad, push, pop;
  logic            key_offer, key_ok;
  logic [7:0]      pt_byte;

  assign mode_dec   = (bus.mode == 2'b01);
  assign fifo_full  = (count_q == CntFull);
  assign fifo_empty = (count_q == '0);

  // Readiness depends only on registered state, never on pt_ready.
  assign ct_rdy  = (state_q == StRun) && !fifo_full;
  assign accept  = bus.ct_valid && ct_rdy;
  assign ct_bad  = ({1'b0, bus.ct_data} >= PMod);
  assign push    = accept && !ct_bad;
  assign pop     = !fifo_empty && bus.pt_ready;

  assign key_offer = (state_q == StWaitKey) && mode_dec && bus.pk_ready;
  assign key_ok    = (bus.pk_in != 8'd0) && ({1'b0, bus.pk_in} < PMod);

  // Modular subtraction; the wrapped sum is formed 9 bits wide and always lands below P_MOD.
  always_comb begin
    pt_byte = 8'd0;
    if (bus.ct_data >= key_q) begin
      pt_byte = bus.ct_data - key_q;
    end else begin
      pt_byte = 8'({1'b0, bus.ct_data} + PMod - {1'b0, key_q});
    end
  end

  // Next-state logic: key intake, run, and drain-before-rekey.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    err_key_d = err_key_q;
    unique case (state_q)
      StWaitKey: begin
        if (key_offer) begin
          if (key_ok) begin
            key_d     = bus.pk_in;
            err_key_d = 1'b0;
            state_d   = StRun;
          end else begin
            err_key_d = 1'b1;
          end
        end
      end
      StRun: begin
        // An accept in this same cycle still completes via push.
        if (!mode_dec) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StWaitKey;
          key_d   = 8'd0;
        end
      end
      default: begin
        state_d = StWaitKey;
        key_d   = 8'd0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitKey;
      key_q      <= 8'd0;
      err_key_q  <= 1'b0;
      err_char_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      err_key_q  <= err_key_d;
      err_char_q <= err_char_d;
    end
  end

  // A rejected byte produces exactly one pulse, one cycle after it was consumed.
  always_comb begin
    err_char_d = accept && ct_bad;
  end

  // FIFO occupancy; push and pop together leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and count; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are don't-care whenever the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pt_byte;
    end
  end

  assign bus.ct_ready         = ct_rdy;
  assign bus.pt_valid         = !fifo_empty;
  assign bus.pt_data          = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.key_loaded       = (state_q == StRun);
  assign bus.err_invalid_key  = err_key_q;
  assign bus.err_invalid_char = err_char_q;

`ifdef CHAR_DECIPHER_COUNT_EN
  logic [15:0] done_q;

  // Saturating count of pushed bytes; restarts with each new key session.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 16'd0;
    end else if ((state_q == StDrain) && (state_d == StWaitKey)) begin
      done_q <= 16'd0;
    end else if (push && (done_q != 16'hFFFF)) begin
      done_q <= done_q + 16'd1;
    end
  end

  assign bus.chars_done = done_q;
`endif

endmodule

// File: tb/tb_char_decipher.sv
// Self-checking bench for char_decipher: directed vector table, hand-written backpressure,
// drain and reset sequences, then randomized traffic against a queue-based reference model.
// Covers CHAR_DECIPHER_COUNT_EN when that macro is defined.
module tb_char_decipher;
  localparam int PMOD  = 227;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] ct;
    logic [7:0] pt;
    logic       bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  char_decipher_if dif ();

  char_decipher #(
    .P_MOD      (PMOD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  vec_t vecs [10];
  int   q [$];
  int   mkey;
  int   mdone;
  int   cd;
  bit   cv, pr, acc, bad, loaded;
  bit   exp_err_char, exp_err_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] pk, input logic pkr,
                       input logic v, input logic [7:0] d, input logic r);
    dif.mode     = m;
    dif.pk_in    = pk;
    dif.pk_ready = pkr;
    dif.ct_valid = v;
    dif.ct_data  = d;
    dif.pt_ready = r;
  endtask

  task automatic check_done(input string name, input int exp);
`ifdef CHAR_DECIPHER_COUNT_EN
    check(name, 32'(dif.chars_done), 32'(exp));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Key 8 (from secret key 10); expected plaintext worked out by hand.
    vecs[0] = '{8'd20,  8'd12,  1'b0};
    vecs[1] = '{8'd8,   8'd0,   1'b0};
    vecs[2] = '{8'd3,   8'd222, 1'b0};
    vecs[3] = '{8'd226, 8'd218, 1'b0};
    vecs[4] = '{8'd230, 8'd0,   1'b1};
    vecs[5] = '{8'd20,  8'd12,  1'b0};
    vecs[6] = '{8'd0,   8'd219, 1'b0};
    vecs[7] = '{8'd227, 8'd0,   1'b1};
    vecs[8] = '{8'd7,   8'd226, 1'b0};
    vecs[9] = '{8'd255, 8'd0,   1'b1};

    // Reset state.
    rst_n = 1'b0;
    drive(2'b00, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_pt_valid", 32'(dif.pt_valid), 0);
    check("rst_pt_data", 32'(dif.pt_data), 0);
    check("rst_ct_ready", 32'(dif.ct_ready), 0);
    check("rst_key_loaded", 32'(dif.key_loaded), 0);
    check("rst_err_key", 32'(dif.err_invalid_key), 0);
    check("rst_err_char", 32'(dif.err_invalid_char), 0);
    check_done("rst_chars_done", 0);
    rst_n = 1'b1;

    // Out-of-range keys are refused and flagged.
    drive(2'b01, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    check("badkey0_err", 32'(dif.err_invalid_key), 1);
    check("badkey0_loaded", 32'(dif.key_loaded), 0);
    check("badkey0_ct_ready", 32'(dif.ct_ready), 0);
    dif.pk_in = 8'd227;
    @(negedge clk);
    check("badkey227_err", 32'(dif.err_invalid_key), 1);
    check("badkey227_loaded", 32'(dif.key_loaded), 0);

    // Valid key 8.
    dif.pk_in = 8'd8;
    @(negedge clk);
    check("key8_loaded", 32'(dif.key_loaded), 1);
    check("key8_ct_ready", 32'(dif.ct_ready), 1);
    check("key8_err_cleared", 32'(dif.err_invalid_key), 0);
    // A new key offered while running must be ignored.
    dif.pk_in    = 8'd50;
    dif.pt_ready = 1'b1;

    // Vector table, one byte per cycle with the sink always ready.
    for (int i = 0; i < 10; i++) begin
      dif.ct_valid = 1'b1;
      dif.ct_data  = vecs[i].ct;
      @(negedge clk);
      check($sformatf("vec%0d_pt_valid", i), 32'(dif.pt_valid), vecs[i].bad ? 0 : 1);
      if (!vecs[i].bad) check($sformatf("vec%0d_pt_data", i), 32'(dif.pt_data), 32'(vecs[i].pt));
      check($sformatf("vec%0d_err_char", i), 32'(dif.err_invalid_char), 32'(vecs[i].bad));
      check($sformatf("vec%0d_ct_ready", i), 32'(dif.ct_ready), 1);
    end
    dif.ct_valid = 1'b0;
    @(negedge clk);
    check("vec_end_pt_valid", 32'(dif.pt_valid), 0);
    check("vec_end_err_char", 32'(dif.err_invalid_char), 0);
    check_done("vec_chars_done", 7);

    // Backpressure: five bytes 20..24 into a stalled sink.
    dif.pt_ready = 1'b0;
    dif.ct_valid = 1'b1;
    dif.ct_data  = 8'd20;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_fill%0d_ct_ready", k), 32'(dif.ct_ready), 1);
      check($sformatf("bp_fill%0d_head", k), 32'(dif.pt_data), 12);
      dif.ct_data = 8'(20 + k);
    end
    @(negedge clk);
    check("bp_full_ct_ready", 32'(dif.ct_ready), 0);
    check("bp_full_head", 32'(dif.pt_data), 12);
    dif.ct_data = 8'd24;
    @(negedge clk);
    check("bp_stall_ct_ready", 32'(dif.ct_ready), 0);
    check("bp_stall_valid", 32'(dif.pt_valid), 1);
    check("bp_stall_head", 32'(dif.pt_data), 12);
    dif.pt_ready = 1'b1;
    @(negedge clk);
    check("bp_pop1_ct_ready", 32'(dif.ct_ready), 1);
    check("bp_pop1_head", 32'(dif.pt_data), 13);
    @(negedge clk);
    check("bp_pop2_head", 32'(dif.pt_data), 14);
    dif.ct_valid = 1'b0;
    @(negedge clk);
    check("bp_pop3_head", 32'(dif.pt_data), 15);
    @(negedge clk);
    check("bp_pop4_head", 32'(dif.pt_data), 16);
    @(negedge clk);
    check("bp_empty", 32'(dif.pt_valid), 0);

    // Drain: three entries queued, then leave decrypt mode.
    dif.pt_ready = 1'b0;
    dif.ct_valid = 1'b1;
    dif.ct_data  = 8'd30;
    @(negedge clk);
    dif.ct_data = 8'd31;
    @(negedge clk);
    dif.ct_data = 8'd32;
    @(negedge clk);
    dif.ct_valid = 1'b0;
    dif.mode     = 2'b00;
    @(negedge clk);
    check("drain_ct_ready", 32'(dif.ct_ready), 0);
    check("drain_key_loaded", 32'(dif.key_loaded), 0);
    check("drain_head0", 32'(dif.pt_data), 22);
    check_done("drain_chars_done", 15);
    // Decrypt mode with a valid key returns early; it must not take effect yet.
    drive(2'b01, 8'd20, 1'b1, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    check("drain_head1", 32'(dif.pt_data), 23);
    check("drain_hold1", 32'(dif.key_loaded), 0);
    @(negedge clk);
    check("drain_head2", 32'(dif.pt_data), 24);
    check("drain_hold2", 32'(dif.key_loaded), 0);
    @(negedge clk);
    check("drain_empty", 32'(dif.pt_valid), 0);
    check("drain_hold3", 32'(dif.key_loaded), 0);
    @(negedge clk);
    check("waitkey_loaded", 32'(dif.key_loaded), 0);
    @(negedge clk);
    check("rekey_loaded", 32'(dif.key_loaded), 1);
    check_done("rekey_chars_done", 0);
    dif.ct_valid = 1'b1;
    dif.ct_data  = 8'd25;
    @(negedge clk);
    check("key20_pt", 32'(dif.pt_data), 5);
    check_done("key20_chars_done", 1);
    dif.ct_valid = 1'b0;
    @(negedge clk);

    // Reset asserted in the middle of a drain.
    dif.pt_ready = 1'b0;
    dif.ct_valid = 1'b1;
    dif.ct_data  = 8'd40;
    @(negedge clk);
    dif.ct_data = 8'd41;
    @(negedge clk);
    dif.ct_data = 8'd42;
    @(negedge clk);
    dif.ct_valid = 1'b0;
    dif.mode     = 2'b00;
    @(negedge clk);
    check("rdrain_head", 32'(dif.pt_data), 20);
    check("rdrain_valid", 32'(dif.pt_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rdrain_rst_valid", 32'(dif.pt_valid), 0);
    check("rdrain_rst_data", 32'(dif.pt_data), 0);
    check("rdrain_rst_loaded", 32'(dif.key_loaded), 0);
    check("rdrain_rst_ct_ready", 32'(dif.ct_ready), 0);
    check_done("rdrain_rst_done", 0);
    drive(2'b01, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_loaded", 32'(dif.key_loaded), 0);
    check("post_rst_ct_ready", 32'(dif.ct_ready), 0);
    check("post_rst_valid", 32'(dif.pt_valid), 0);

    // Randomized sessions against the reference model.
    exp_err_key = 1'b0;
    for (int round = 0; round < 3; round++) begin
      loaded = 1'b0;
      for (int t = 0; t < 16 && !loaded; t++) begin
        mkey = (t == 15) ? int'($urandom_range(1, PMOD - 1)) : int'($urandom_range(0, 255));
        drive(2'b01, 8'(mkey), 1'b1, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        if (mkey >= 1 && mkey < PMOD) begin
          loaded      = 1'b1;
          exp_err_key = 1'b0;
        end else begin
          exp_err_key = 1'b1;
        end
        check("rnd_key_loaded", 32'(dif.key_loaded), 32'(loaded));
        check("rnd_err_key", 32'(dif.err_invalid_key), 32'(exp_err_key));
      end

      q.delete();
      mdone        = 0;
      exp_err_char = 1'b0;
      for (int c = 0; c < 500; c++) begin
        check("rnd_pt_valid", 32'(dif.pt_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) check("rnd_pt_data", 32'(dif.pt_data), 32'(q[0]));
        check("rnd_ct_ready", 32'(dif.ct_ready), (q.size() < DEPTH) ? 1 : 0);
        check("rnd_err_char", 32'(dif.err_invalid_char), 32'(exp_err_char));
        check("rnd_key_loaded_run", 32'(dif.key_loaded), 1);
        check_done("rnd_chars_done", mdone);

        cv = ($urandom_range(0, 3) != 0);
        cd = ($urandom_range(0, 4) == 0) ? int'($urandom_range(PMOD, 255))
                                         : int'($urandom_range(0, PMOD - 1));
        pr = ($urandom_range(0, 9) < 7);
        drive(2'b01, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), cv, 8'(cd), pr);

        acc = cv && (q.size() < DEPTH);
        bad = acc && (cd >= PMOD);
        if (pr && q.size() != 0) void'(q.pop_front());
        if (acc && !bad) begin
          q.push_back((cd - mkey + PMOD) % PMOD);
          if (mdone < 65535) mdone++;
        end
        exp_err_char = bad;
        @(negedge clk);
      end

      // Leave decrypt mode and watch the remaining entries come out in order.
      drive(2'b00, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1);
      for (int c = 0; c < DEPTH + 2; c++) begin
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        check("rnd_drain_valid", 32'(dif.pt_valid), (q.size() != 0) ? 1 : 0);
        if (q.size() != 0) check("rnd_drain_data", 32'(dif.pt_data), 32'(q[0]));
        check("rnd_drain_ct_ready", 32'(dif.ct_ready), 0);
        check("rnd_drain_loaded", 32'(dif.key_loaded), 0);
      end
      check_done("rnd_drain_done", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
